// File: rtl/sop_frame_sequencer.sv
// sop_frame_sequencer
// Turns each accepted start-of-processing pulse into one frame of beat indices
// 0..len-1 on a valid/ready stream. It tags each frame with a wrapping frame id.
// It counts SOPs that are dropped because a frame is still running.
// Optional build macro: SOP_WATCHDOG_EN adds a watchdog that raises sop_missing
// when no SOP arrives for WD_LIMIT cycles.
//
// Stream handshake: a beat transfers on a rising clk_line edge where out_valid
// and out_ready are both high. While out_valid is high, out_idx, out_last and
// out_frame_id stay stable until that transfer. out_valid never depends
// combinationally on out_ready.
module sop_frame_sequencer #(
    parameter int LEN_W    = 8,
    parameter int FID_W    = 4,
    parameter int OVR_W    = 8,
    parameter int WD_LIMIT = 300
) (
    input  logic             clk_line,
    input  logic             rst,
    input  logic             plain_in_start_of_processing,
    input  logic             enable,
    input  logic [LEN_W-1:0] cfg_frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] out_idx,
    output logic             out_last,
    output logic [FID_W-1:0] out_frame_id,
    output logic             busy,
    output logic             overrun_pulse,
    output logic [OVR_W-1:0] overrun_cnt,
    output logic             sop_missing
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic             r_last;
    logic [FID_W-1:0] r_fid;
    logic             r_ovr_pulse;
    logic [OVR_W-1:0] r_ovr_cnt;

    logic             w_sop_en;
    logic             w_final_hs;
    logic             w_accept;
    logic             w_overrun;
    logic [LEN_W-1:0] w_idx_inc;
    logic [LEN_W-1:0] w_len_m1;

    // An enabled SOP either starts a frame, is ignored (zero length), or is dropped.
    // A frame may only start when the previous one ends on this same edge.
    assign w_sop_en   = plain_in_start_of_processing && enable;
    assign w_final_hs = (r_state == RUN) && r_last && out_ready;
    assign w_accept   = w_sop_en && (cfg_frame_len != '0) && ((r_state == IDLE) || w_final_hs);
    assign w_overrun  = w_sop_en && (r_state == RUN) && !w_final_hs;
    assign w_idx_inc  = r_idx + LEN_W'(1);
    assign w_len_m1   = r_len - LEN_W'(1);

    // State register
    always_ff @(posedge clk_line) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic: an accept wins over the end of the current frame (back-to-back)
    always_comb begin
        w_state_next = r_state;
        if (w_accept)        w_state_next = RUN;
        else if (w_final_hs) w_state_next = IDLE;
    end

    // Beat index, last flag, latched length and frame id
    always_ff @(posedge clk_line) begin
        if (rst) begin
            r_len  <= '0;
            r_idx  <= '0;
            r_last <= 1'b0;
            r_fid  <= '0;
        end else if (w_accept) begin
            r_len  <= cfg_frame_len;
            r_idx  <= '0;
            r_last <= (cfg_frame_len == LEN_W'(1));
            r_fid  <= r_fid + FID_W'(1);
        end else if (w_final_hs) begin
            r_idx  <= '0;
            r_last <= 1'b0;
        end else if ((r_state == RUN) && out_ready) begin
            r_idx  <= w_idx_inc;
            r_last <= (w_idx_inc == w_len_m1);
        end
    end

    // Dropped-SOP pulse and saturating counter
    always_ff @(posedge clk_line) begin
        if (rst) begin
            r_ovr_pulse <= 1'b0;
            r_ovr_cnt   <= '0;
        end else begin
            r_ovr_pulse <= w_overrun;
            if (w_overrun && (r_ovr_cnt != '1)) r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
        end
    end

`ifdef SOP_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_missing;

    // Watchdog: cycles since last SOP (enable ignored), sticky flag at the limit
    always_ff @(posedge clk_line) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_missing <= 1'b0;
        end else if (plain_in_start_of_processing) begin
            r_wd_cnt  <= '0;
            r_missing <= 1'b0;
        end else begin
            if (r_wd_cnt != WD_W'(WD_LIMIT)) r_wd_cnt <= r_wd_cnt + WD_W'(1);
            else                             r_missing <= 1'b1;
        end
    end

    assign sop_missing = r_missing;
`else
    assign sop_missing = 1'b0;
`endif

    assign out_valid     = (r_state == RUN);
    assign busy          = (r_state == RUN);
    assign out_idx       = r_idx;
    assign out_last      = r_last;
    assign out_frame_id  = r_fid;
    assign overrun_pulse = r_ovr_pulse;
    assign overrun_cnt   = r_ovr_cnt;

endmodule

// File: tb/tb_sop_frame_sequencer.sv
// Directed bench for sop_frame_sequencer. A second instance with a 2-bit overrun
// counter shares all inputs, so its saturation can be observed.
module tb_sop_frame_sequencer;

    logic       clk_line = 1'b0;
    logic       rst;
    logic       sop;
    logic       enable;
    logic       out_ready;
    logic [7:0] cfg_len;

    logic       out_valid, out_last, busy, overrun_pulse, sop_missing;
    logic [7:0] out_idx;
    logic [3:0] out_frame_id;
    logic [7:0] overrun_cnt;

    logic       d2_valid, d2_last, d2_busy, d2_pulse, d2_missing;
    logic [7:0] d2_idx;
    logic [3:0] d2_fid;
    logic [1:0] d2_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_line = ~clk_line;

    sop_frame_sequencer u_dut (
        .clk_line(clk_line), .rst(rst), .plain_in_start_of_processing(sop), .enable(enable),
        .cfg_frame_len(cfg_len), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_frame_id(out_frame_id), .busy(busy),
        .overrun_pulse(overrun_pulse), .overrun_cnt(overrun_cnt), .sop_missing(sop_missing)
    );

    sop_frame_sequencer #(.OVR_W(2)) u_dut_ovr2 (
        .clk_line(clk_line), .rst(rst), .plain_in_start_of_processing(sop), .enable(enable),
        .cfg_frame_len(cfg_len), .out_valid(d2_valid), .out_ready(out_ready), .out_idx(d2_idx),
        .out_last(d2_last), .out_frame_id(d2_fid), .busy(d2_busy),
        .overrun_pulse(d2_pulse), .overrun_cnt(d2_cnt), .sop_missing(d2_missing)
    );

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_line);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sop = 1'b0; enable = 1'b1; out_ready = 1'b1; cfg_len = 8'd4;
        step(); step();
        n_checks++;
        if ({out_valid, busy, out_last, out_idx, out_frame_id, overrun_pulse, overrun_cnt, sop_missing} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b b=%b l=%b idx=%0d fid=%0d p=%b cnt=%0d m=%b, expected all 0",
                     out_valid, busy, out_last, out_idx, out_frame_id, overrun_pulse, overrun_cnt, sop_missing);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({out_valid, busy, out_frame_id} !== 6'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got v=%b b=%b fid=%0d, expected 0 0 0", out_valid, busy, out_frame_id);
        end
    endtask

    // Three frames of 4 beats, one SOP every 256 cycles, sink always ready.
    task automatic test_periodic();
        logic [13:0] exp_v;
        for (int f = 1; f <= 3; f++) begin
            sop = 1'b1; cfg_len = 8'd4;
            step();
            sop = 1'b0;
            for (int k = 0; k < 4; k++) begin
                exp_v = {1'b1, 8'(k), (k == 3), 4'(f)};
                n_checks++;
                if ({out_valid, out_idx, out_last, out_frame_id} !== exp_v) begin
                    n_fail++;
                    $display("FAIL periodic_beat f%0d k%0d: got %h expected %h", f, k,
                             {out_valid, out_idx, out_last, out_frame_id}, exp_v);
                end
                step();
            end
            n_checks++;
            if ({out_valid, busy, overrun_cnt} !== 10'h0) begin
                n_fail++;
                $display("FAIL periodic_end f%0d: got v=%b b=%b cnt=%0d expected 0 0 0", f, out_valid, busy, overrun_cnt);
            end
            repeat (256 - 5) step();
        end
    endtask

    // Sink alternates stall/ready; index and last must hold on stall cycles.
    task automatic test_stall();
        int exp_idx = 0;
        int hs      = 0;
        sop = 1'b1; cfg_len = 8'd4; out_ready = 1'b0;
        step();
        sop = 1'b0;
        for (int c = 0; c < 20 && hs < 4; c++) begin
            n_checks++;
            if ({out_valid, out_idx, out_last, out_frame_id} !== {1'b1, 8'(exp_idx), (exp_idx == 3), 4'd4}) begin
                n_fail++;
                $display("FAIL stall_beat c%0d: got v=%b idx=%0d l=%b fid=%0d expected 1 %0d %b 4",
                         c, out_valid, out_idx, out_last, out_frame_id, exp_idx, (exp_idx == 3));
            end
            out_ready = c[0];
            step();
            if (out_ready) begin
                hs++;
                exp_idx++;
            end
        end
        n_checks++;
        if (hs != 4 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: got hs=%0d v=%b b=%b expected 4 0 0", hs, out_valid, busy);
        end
        out_ready = 1'b1;
    endtask

    // Long stalled frame; five SOPs dropped while it runs.
    task automatic test_overrun();
        logic [1:0] e2;
        int         beats = 0;
        out_ready = 1'b0; cfg_len = 8'd200; sop = 1'b1;
        step();
        sop = 1'b0;
        repeat (40) step();
        n_checks++;
        if ({out_valid, out_idx, out_last, out_frame_id} !== {1'b1, 8'd0, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL overrun_hold: got v=%b idx=%0d l=%b fid=%0d expected 1 0 0 5",
                     out_valid, out_idx, out_last, out_frame_id);
        end
        for (int d = 1; d <= 5; d++) begin
            e2 = (d > 3) ? 2'd3 : 2'(d);
            sop = 1'b1;
            step();
            sop = 1'b0;
            n_checks++;
            if ({overrun_pulse, overrun_cnt, d2_cnt, out_frame_id} !== {1'b1, 8'(d), e2, 4'd5}) begin
                n_fail++;
                $display("FAIL overrun_drop d%0d: got p=%b cnt=%0d cnt2=%0d fid=%0d expected 1 %0d %0d 5",
                         d, overrun_pulse, overrun_cnt, d2_cnt, out_frame_id, d, e2);
            end
            step();
            n_checks++;
            if (overrun_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL overrun_pulse_width d%0d: got %b expected 0", d, overrun_pulse);
            end
            repeat (50) step();
        end
        cfg_len = 8'd9;
        out_ready = 1'b1;
        for (int c = 0; c < 260; c++) begin
            if (!out_valid) break;
            n_checks++;
            if (out_idx !== 8'(beats) || out_last !== (beats == 199)) begin
                n_fail++;
                $display("FAIL overrun_drain_beat %0d: got idx=%0d l=%b", beats, out_idx, out_last);
            end
            beats++;
            step();
        end
        n_checks++;
        if (beats != 200 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain_len: got beats=%0d v=%b expected 200 0", beats, out_valid);
        end
    endtask

    // SOP on the final handshake, zero length, enable low in IDLE and in RUN.
    task automatic test_back_to_back();
        cfg_len = 8'd4; out_ready = 1'b1; sop = 1'b1;
        step();
        sop = 1'b0;
        step(); step(); step();
        n_checks++;
        if ({out_idx, out_last, out_frame_id} !== {8'd3, 1'b1, 4'd6}) begin
            n_fail++;
            $display("FAIL b2b_last: got idx=%0d l=%b fid=%0d expected 3 1 6", out_idx, out_last, out_frame_id);
        end
        sop = 1'b1;
        step();
        sop = 1'b0;
        n_checks++;
        if ({out_valid, out_idx, out_last, out_frame_id, overrun_pulse, overrun_cnt} !== {1'b1, 8'd0, 1'b0, 4'd7, 1'b0, 8'd5}) begin
            n_fail++;
            $display("FAIL b2b_restart: got v=%b idx=%0d l=%b fid=%0d p=%b cnt=%0d expected 1 0 0 7 0 5",
                     out_valid, out_idx, out_last, out_frame_id, overrun_pulse, overrun_cnt);
        end
        step(); step(); step(); step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b expected 0", out_valid);
        end
        cfg_len = 8'd0; sop = 1'b1;
        step();
        sop = 1'b0;
        n_checks++;
        if ({out_valid, out_frame_id, overrun_pulse} !== {1'b0, 4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL len0_ignored: got v=%b fid=%0d p=%b expected 0 7 0", out_valid, out_frame_id, overrun_pulse);
        end
        cfg_len = 8'd4; enable = 1'b0; sop = 1'b1;
        step();
        sop = 1'b0; enable = 1'b1;
        n_checks++;
        if ({out_valid, out_frame_id, overrun_pulse} !== {1'b0, 4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL disabled_idle: got v=%b fid=%0d p=%b expected 0 7 0", out_valid, out_frame_id, overrun_pulse);
        end
        sop = 1'b1;
        step();
        enable = 1'b0;
        step();
        sop = 1'b0; enable = 1'b1;
        step();
        n_checks++;
        if ({out_valid, out_idx, out_frame_id, overrun_pulse, overrun_cnt} !== {1'b1, 8'd2, 4'd8, 1'b0, 8'd5}) begin
            n_fail++;
            $display("FAIL disabled_run: got v=%b idx=%0d fid=%0d p=%b cnt=%0d expected 1 2 8 0 5",
                     out_valid, out_idx, out_frame_id, overrun_pulse, overrun_cnt);
        end
        for (int c = 0; c < 20 && out_valid; c++) step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_run_drain: got v=%b expected 0", out_valid);
        end
    endtask

    // Reset in the middle of a frame aborts it; numbering restarts at 1.
    task automatic test_midreset();
        cfg_len = 8'd4; sop = 1'b1;
        step();
        sop = 1'b0;
        step(); step();
        n_checks++;
        if ({out_idx, out_frame_id} !== {8'd2, 4'd9}) begin
            n_fail++;
            $display("FAIL midreset_pre: got idx=%0d fid=%0d expected 2 9", out_idx, out_frame_id);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({out_valid, busy, out_last, out_idx, out_frame_id, overrun_pulse, overrun_cnt, sop_missing} !== 24'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got v=%b b=%b l=%b idx=%0d fid=%0d p=%b cnt=%0d m=%b expected all 0",
                     out_valid, busy, out_last, out_idx, out_frame_id, overrun_pulse, overrun_cnt, sop_missing);
        end
        rst = 1'b0;
        step();
        sop = 1'b1;
        step();
        sop = 1'b0;
        n_checks++;
        if ({out_valid, out_idx, out_frame_id} !== {1'b1, 8'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL midreset_restart: got v=%b idx=%0d fid=%0d expected 1 0 1", out_valid, out_idx, out_frame_id);
        end
        for (int c = 0; c < 20 && out_valid; c++) step();
    endtask

    // No SOP for more than WD_LIMIT cycles, then one SOP.
    task automatic test_watchdog();
        logic exp_missing;
`ifdef SOP_WATCHDOG_EN
        exp_missing = 1'b1;
`else
        exp_missing = 1'b0;
`endif
        repeat (320) step();
        n_checks++;
        if (sop_missing !== exp_missing) begin
            n_fail++;
            $display("FAIL watchdog_set: got %b expected %b", sop_missing, exp_missing);
        end
        cfg_len = 8'd4; sop = 1'b1;
        step();
        sop = 1'b0;
        n_checks++;
        if (sop_missing !== 1'b0) begin
            n_fail++;
            $display("FAIL watchdog_clear: got %b expected 0", sop_missing);
        end
        for (int c = 0; c < 20 && out_valid; c++) step();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_midreset();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
